// File: rtl/cache_req_frontend_if.sv
// ---------------------------------------------------------------------------
// cache_req_frontend_if
// Purpose : CPU-side request/response handshake bundle for cache_req_frontend.
// Signals : req_valid/req_ready/req_write/req_addr/req_wdata   (request)
//           rsp_valid/rsp_ready/rsp_write/rsp_hit/rsp_rdata    (response)
// Modports: master = CPU side, slave = frontend side.
// ---------------------------------------------------------------------------
interface cache_req_frontend_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic              rsp_hit;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_hit, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_hit, rsp_rdata
    );
endinterface

// File: rtl/cache_req_frontend.sv
// ---------------------------------------------------------------------------
// cache_req_frontend
// Purpose : Buffers CPU requests in a FIFO and issues them one at a time to the
//           downstream 2-way cache, returning hit/read data as a valid/ready
//           response. One request in flight; responses in acceptance order.
// Ports   : clk, rst (synchronous, active-high)
//           cpu               CPU request/response bundle (slave modport)
//           q_count           FIFO occupancy
//           cache_read_en/cache_write_en/cache_address/cache_write_data
//                             issue port to the cache
//           cache_read_data   registered read data from the cache
//           cache_hit         combinational hit from the cache
//           stat_reads/stat_writes/stat_hits  statistics counters
// Config  : CACHE_REQ_STATS_EN enables saturating statistics counters;
//           otherwise the stat_* ports are tied to 0.
// ---------------------------------------------------------------------------
module cache_req_frontend #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_req_frontend_if.slave    cpu,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   cache_read_en,
    output logic                   cache_write_en,
    output logic [ADDR_W-1:0]      cache_address,
    output logic [DATA_W-1:0]      cache_write_data,
    input  logic [DATA_W-1:0]      cache_read_data,
    input  logic                   cache_hit,
    output logic [STAT_W-1:0]      stat_reads,
    output logic [STAT_W-1:0]      stat_writes,
    output logic [STAT_W-1:0]      stat_hits
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state;
    req_t              fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              issue_wr;

    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic              rsp_hit_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;
    req_t              head_c;

    assign full_c  = (q_count == CNT_W'(DEPTH));
    assign empty_c = (q_count == '0);
    assign push_c  = cpu.req_valid && !full_c;
    // Head leaves the FIFO when the issue slot frees up: from IDLE, or as the
    // current response is accepted.
    assign pop_c   = !empty_c &&
                     ((state == IDLE) || ((state == RESP) && cpu.rsp_ready));
    assign head_c  = fifo_mem[rd_ptr];

    assign cpu.req_ready = !full_c;
    assign cpu.rsp_valid = rsp_valid_q;
    assign cpu.rsp_write = rsp_write_q;
    assign cpu.rsp_hit   = rsp_hit_q;
    assign cpu.rsp_rdata = rsp_rdata_q;

    // FIFO storage (no reset needed; validity is tracked by q_count).
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= '{wr: cpu.req_write, addr: cpu.req_addr,
                                  wdata: cpu.req_wdata};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   q_count <= q_count + CNT_W'(1);
                2'b01:   q_count <= q_count - CNT_W'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Issue/response sequencer with registered cache and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            issue_wr         <= 1'b0;
            cache_read_en    <= 1'b0;
            cache_write_en   <= 1'b0;
            cache_address    <= '0;
            cache_write_data <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_write_q      <= 1'b0;
            rsp_hit_q        <= 1'b0;
            rsp_rdata_q      <= '0;
        end else begin
            // Loading the head is shared by the IDLE and RESP exits.
            if (pop_c) begin
                cache_address    <= head_c.addr;
                cache_write_data <= head_c.wdata;
                issue_wr         <= head_c.wr;
                cache_read_en    <= !head_c.wr;
                cache_write_en   <= head_c.wr;
            end

            case (state)
                IDLE: begin
                    if (pop_c) state <= ISSUE;
                end
                ISSUE: begin
                    cache_read_en  <= 1'b0;
                    cache_write_en <= 1'b0;
                    rsp_hit_q      <= cache_hit;
                    rsp_write_q    <= issue_wr;
                    state          <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_rdata_q <= issue_wr ? '0 : cache_read_data;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (cpu.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= pop_c ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_REQ_STATS_EN
    // Saturating statistics, updated at the end of each ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_hits   <= '0;
        end else if (state == ISSUE) begin
            if (issue_wr && (stat_writes != '1))
                stat_writes <= stat_writes + STAT_W'(1);
            if (!issue_wr && (stat_reads != '1))
                stat_reads <= stat_reads + STAT_W'(1);
            if (cache_hit && (stat_hits != '1))
                stat_hits <= stat_hits + STAT_W'(1);
        end
    end
`else
    assign stat_reads  = '0;
    assign stat_writes = '0;
    assign stat_hits   = '0;
`endif

endmodule

// File: tb/tb_cache_req_frontend.sv
// ---------------------------------------------------------------------------
// tb_cache_req_frontend
// Purpose : Self-checking bench for cache_req_frontend with a small behavioural
//           cache downstream (combinational hit, registered read data,
//           allocate on miss, miss read data 0, line data initialised to its
//           address, write-allocate). Cache and frontend share the reset.
// ---------------------------------------------------------------------------
module tb_cache_req_frontend;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STAT_W = 16;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned LINES  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_req_frontend_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu ();

    logic [CNT_W-1:0]  q_count;
    logic              cache_read_en;
    logic              cache_write_en;
    logic [ADDR_W-1:0] cache_address;
    logic [DATA_W-1:0] cache_write_data;
    logic [DATA_W-1:0] cache_read_data;
    logic              cache_hit;
    logic [STAT_W-1:0] stat_reads;
    logic [STAT_W-1:0] stat_writes;
    logic [STAT_W-1:0] stat_hits;

    cache_req_frontend #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STAT_W(STAT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cpu              (cpu),
        .q_count          (q_count),
        .cache_read_en    (cache_read_en),
        .cache_write_en   (cache_write_en),
        .cache_address    (cache_address),
        .cache_write_data (cache_write_data),
        .cache_read_data  (cache_read_data),
        .cache_hit        (cache_hit),
        .stat_reads       (stat_reads),
        .stat_writes      (stat_writes),
        .stat_hits        (stat_hits)
    );

    // Behavioural cache model.
    logic              line_v    [LINES];
    logic [ADDR_W-1:0] line_tag  [LINES];
    logic [DATA_W-1:0] line_data [LINES];
    logic [2:0]        alloc_ptr;
    logic              lookup_hit;
    logic [2:0]        lookup_idx;

    always_comb begin
        lookup_hit = 1'b0;
        lookup_idx = 3'd0;
        for (int i = 0; i < int'(LINES); i++) begin
            if (line_v[i] && (line_tag[i] == cache_address)) begin
                lookup_hit = 1'b1;
                lookup_idx = 3'(i);
            end
        end
    end

    assign cache_hit = lookup_hit && (cache_read_en || cache_write_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LINES); i++) line_v[i] <= 1'b0;
            alloc_ptr       <= 3'd0;
            cache_read_data <= '0;
        end else if (cache_read_en) begin
            if (lookup_hit) begin
                cache_read_data <= line_data[lookup_idx];
            end else begin
                cache_read_data      <= '0;
                line_v[alloc_ptr]    <= 1'b1;
                line_tag[alloc_ptr]  <= cache_address;
                line_data[alloc_ptr] <= cache_address;
                alloc_ptr            <= alloc_ptr + 3'd1;
            end
        end else if (cache_write_en) begin
            if (lookup_hit) begin
                line_data[lookup_idx] <= cache_write_data;
            end else begin
                line_v[alloc_ptr]    <= 1'b1;
                line_tag[alloc_ptr]  <= cache_address;
                line_data[alloc_ptr] <= cache_write_data;
                alloc_ptr            <= alloc_ptr + 3'd1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    // Present one request and hold it until accepted.
    task automatic send(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
        logic got;
        got = 1'b0;
        @(negedge clk);
        cpu.req_valid = 1'b1;
        cpu.req_write = wr;
        cpu.req_addr  = addr;
        cpu.req_wdata = wdata;
        for (int t = 0; t < 20 && !got; t++) begin
            got = cpu.req_ready;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        #1 cpu.req_valid = 1'b0;
        if (!got) check("push_timeout", 64'(0), 64'(1));
    endtask

    // Single request into an idle frontend: checks issue cycle, latency, response.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        lat = 0;
        send(v.wr, v.addr, v.wdata);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) begin
                check({tag, "_issue_rd_en"}, 64'(cache_read_en), 64'(!v.wr));
                check({tag, "_issue_wr_en"}, 64'(cache_write_en), 64'(v.wr));
                check({tag, "_issue_addr"}, 64'(cache_address), 64'(v.addr));
            end
            if (cpu.rsp_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(4));
        check({tag, "_rsp_write"}, 64'(cpu.rsp_write), 64'(v.wr));
        check({tag, "_rsp_hit"}, 64'(cpu.rsp_hit), 64'(v.exp_hit));
        check({tag, "_rsp_rdata"}, 64'(cpu.rsp_rdata), 64'(v.exp_rdata));
    endtask

    vec_t vecs [4];
    vec_t burst [5];
    vec_t post_rst;

    initial begin
        int  j;
        logic saw_valid;

        vecs[0] = '{wr: 1'b0, addr: 32'h40, wdata: 32'h0, exp_hit: 1'b0, exp_rdata: 32'h0};
        vecs[1] = '{wr: 1'b0, addr: 32'h40, wdata: 32'h0, exp_hit: 1'b1, exp_rdata: 32'h40};
        vecs[2] = '{wr: 1'b1, addr: 32'h80, wdata: 32'hDEADBEEF, exp_hit: 1'b0, exp_rdata: 32'h0};
        vecs[3] = '{wr: 1'b0, addr: 32'h80, wdata: 32'h0, exp_hit: 1'b1, exp_rdata: 32'hDEADBEEF};

        burst[0] = '{wr: 1'b0, addr: 32'h40,  wdata: 32'h0, exp_hit: 1'b1, exp_rdata: 32'h40};
        burst[1] = '{wr: 1'b0, addr: 32'h80,  wdata: 32'h0, exp_hit: 1'b1, exp_rdata: 32'hDEADBEEF};
        burst[2] = '{wr: 1'b0, addr: 32'h200, wdata: 32'h0, exp_hit: 1'b0, exp_rdata: 32'h0};
        burst[3] = '{wr: 1'b0, addr: 32'h200, wdata: 32'h0, exp_hit: 1'b1, exp_rdata: 32'h200};
        burst[4] = '{wr: 1'b0, addr: 32'hC0,  wdata: 32'h0, exp_hit: 1'b0, exp_rdata: 32'h0};

        post_rst = '{wr: 1'b0, addr: 32'h40, wdata: 32'h0, exp_hit: 1'b0, exp_rdata: 32'h0};

        // Reset state.
        rst           = 1'b1;
        cpu.req_valid = 1'b0;
        cpu.req_write = 1'b0;
        cpu.req_addr  = '0;
        cpu.req_wdata = '0;
        cpu.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(cpu.req_ready), 64'(1));
        check("rst_rsp_valid", 64'(cpu.rsp_valid), 64'(0));
        check("rst_q_count", 64'(q_count), 64'(0));
        check("rst_rd_en", 64'(cache_read_en), 64'(0));
        check("rst_wr_en", 64'(cache_write_en), 64'(0));
        check("rst_rsp_rdata", 64'(cpu.rsp_rdata), 64'(0));
        check("rst_cache_addr", 64'(cache_address), 64'(0));
        check("rst_stat_reads", 64'(stat_reads), 64'(0));
        rst = 1'b0;

        // Basic read/write table.
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        @(negedge clk);
        check("vec_rsp_valid_cleared", 64'(cpu.rsp_valid), 64'(0));

        // Statistics after the read/write table.
`ifdef CACHE_REQ_STATS_EN
        check("stat_reads", 64'(stat_reads), 64'(3));
        check("stat_writes", 64'(stat_writes), 64'(1));
        check("stat_hits", 64'(stat_hits), 64'(2));
`else
        check("stat_reads", 64'(stat_reads), 64'(0));
        check("stat_writes", 64'(stat_writes), 64'(0));
        check("stat_hits", 64'(stat_hits), 64'(0));
`endif

        // Back-pressure: one request in flight plus DEPTH queued fills the FIFO.
        cpu.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(burst[i].wr, burst[i].addr, burst[i].wdata);
        end
        @(negedge clk);
        check("full_q_count", 64'(q_count), 64'(DEPTH));
        check("full_req_ready", 64'(cpu.req_ready), 64'(0));
        check("full_rsp_valid", 64'(cpu.rsp_valid), 64'(1));
        // Offer an extra request while full; it must not be taken.
        cpu.req_valid = 1'b1;
        cpu.req_write = 1'b0;
        cpu.req_addr  = 32'h999;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("full_no_push", 64'(q_count), 64'(DEPTH));
            check("full_rsp_stable", 64'(cpu.rsp_rdata), 64'(burst[0].exp_rdata));
        end
        cpu.req_valid = 1'b0;
        cpu.rsp_ready = 1'b1;
        j = 0;
        for (int t = 0; t < 60 && j < 5; t++) begin
            if (cpu.rsp_valid) begin
                check($sformatf("burst%0d_hit", j), 64'(cpu.rsp_hit), 64'(burst[j].exp_hit));
                check($sformatf("burst%0d_rdata", j), 64'(cpu.rsp_rdata), 64'(burst[j].exp_rdata));
                j++;
            end
            @(negedge clk);
        end
        check("burst_rsp_count", 64'(j), 64'(5));
        repeat (2) @(negedge clk);
        check("burst_q_count_empty", 64'(q_count), 64'(0));
        check("burst_req_ready", 64'(cpu.req_ready), 64'(1));

        // Reset while the first of two queued reads is in CAPTURE.
        send(1'b0, 32'h300, 32'h0);
        send(1'b0, 32'h304, 32'h0);
        @(negedge clk);
        check("midrst_issue_rd_en", 64'(cache_read_en), 64'(1));
        @(negedge clk);
        check("midrst_capture_q_count", 64'(q_count), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_q_count", 64'(q_count), 64'(0));
        check("midrst_rsp_valid", 64'(cpu.rsp_valid), 64'(0));
        check("midrst_rd_en", 64'(cache_read_en), 64'(0));
        check("midrst_stat_hits", 64'(stat_hits), 64'(0));
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (cpu.rsp_valid || cache_read_en || cache_write_en) saw_valid = 1'b1;
        end
        check("midrst_no_activity", 64'(saw_valid), 64'(0));
        run_vec(post_rst, "post_rst");

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
